// File: rtl/dbus_bridge.sv
// dbus_bridge: data-side bus bridge that sits directly downstream of the core's data port.
//
// Address map:
//   mem_addr[31]==0         local word RAM. Reads are registered with one cycle of latency.
//                           Word index is mem_addr[log2(RAM_WORDS)+1:2]; higher address bits alias.
//   mem_addr[31]==1         MMIO region. Stores are posted into a write buffer FIFO.
//                           Loads return the bridge status word.
//   mem_addr==FFFF_FFFC     control address. A store here clears wbuf_overflow and the drop count.
//
// The bridge never back-pressures the core. An MMIO store that finds the FIFO full
// (and no pop in the same cycle) is dropped and sets the sticky wbuf_overflow flag.
//
// Status word: [31] overflow, [30] full, [29] empty, [23:8] drop count, [7:0] occupancy.
//
// Optional feature: define DBUS_DROP_COUNT_EN to build a 16-bit saturating drop counter.
// Without it, status[23:8] reads 0.
//
// Ports:
//   clk, reset        single clock; asynchronous active-high reset
//   mem_addr/wdata    core memory-stage address and store data
//   mem_write         store strobe (low = load or idle)
//   mem_rdata         registered read data, valid the cycle after the address
//   io_valid/ready    write-buffer drain handshake
//   io_addr/wdata     write-buffer head entry
//   wbuf_overflow     sticky dropped-store flag
module dbus_bridge #(
  parameter int RAM_WORDS  = 1024,
  parameter int WBUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_write,
  output logic [31:0] mem_rdata,
  output logic        io_valid,
  input  logic        io_ready,
  output logic [31:0] io_addr,
  output logic [31:0] io_wdata,
  output logic        wbuf_overflow
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0] ram [RAM_WORDS];

  logic [31:0] fifo_addr [WBUF_DEPTH];
  logic [31:0] fifo_data [WBUF_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [15:0]   drop_cnt;

  logic [AW-1:0] ram_idx;
  logic          is_mmio, is_ctrl;
  logic          mmio_store, ctrl_store, ram_store;
  logic          full, empty, pop, push, drop;
  logic [7:0]    occ;
  logic [31:0]   status;
  logic          unused_addr_bits;

  assign ram_idx    = mem_addr[AW+1:2];
  assign is_mmio    = mem_addr[31];
  assign is_ctrl    = (mem_addr == 32'hFFFF_FFFC);
  assign ram_store  = mem_write & ~is_mmio;
  assign ctrl_store = mem_write & is_ctrl;
  assign mmio_store = mem_write & is_mmio & ~is_ctrl;

  assign full  = (count == CW'(WBUF_DEPTH));
  assign empty = (count == '0);
  assign pop   = io_valid & io_ready;
  // A pop in the same cycle frees the slot the push needs, so a full FIFO still accepts it.
  assign push  = mmio_store & (~full | pop);
  assign drop  = mmio_store & full & ~pop;

  assign occ    = 8'(count);
  // Built from registered state only, so a status load sees the state before this cycle's push/pop.
  assign status = {wbuf_overflow, full, empty, 5'b0, drop_cnt, occ};

  assign io_valid = ~empty;
  assign io_addr  = fifo_addr[rd_ptr];
  assign io_wdata = fifo_data[rd_ptr];

  assign unused_addr_bits = &{1'b0, mem_addr[30:AW+2], mem_addr[1:0]};

  // RAM array: no reset. The read below samples the old word on a same-index write.
  always_ff @(posedge clk) begin
    if (ram_store) ram[ram_idx] <= mem_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_rdata <= '0;
    end else if (!is_mmio) begin
      mem_rdata <= ram[ram_idx];
    end else if (!mem_write) begin
      mem_rdata <= status;
    end
  end

  // FIFO storage is reset so io_addr/io_wdata come up at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WBUF_DEPTH; i++) begin
        fifo_addr[i] <= '0;
        fifo_data[i] <= '0;
      end
    end else if (push) begin
      fifo_addr[wr_ptr] <= mem_addr;
      fifo_data[wr_ptr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A clear and a drop in the same cycle: the clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbuf_overflow <= 1'b0;
    end else if (ctrl_store) begin
      wbuf_overflow <= 1'b0;
    end else if (drop) begin
      wbuf_overflow <= 1'b1;
    end
  end

`ifdef DBUS_DROP_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (ctrl_store) begin
      drop_cnt <= '0;
    end else if (drop && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: doc/dbus_bridge.md
# dbus_bridge

Data-side bus bridge placed directly downstream of the `cpu` data port (`mem_addr`, `mem_wdata`, `mem_write`, `mem_rdata`).

- **RAM region:** decodes each memory-stage access into a local word RAM with a one-cycle registered read. This matches the core's writeback-stage sampling of `mem_rdata`.
- **MMIO region:** stores are posted into a write buffer FIFO that drains over a valid/ready bus.
- **No back-pressure:** the core cannot stall on data accesses, so the bridge never stalls it. Overflowing stores are dropped and flagged.

## Interface

Parameters:
- `RAM_WORDS`, 1024: local RAM depth in 32-bit words. Power of 2.
- `WBUF_DEPTH`, 4: MMIO write buffer entries. Power of 2, ≥2, ≤128.

Ports (reset is asynchronous, active-high):
- `clk`  in  1  — the single clock.
- `reset`  in  1  — asynchronous, active-high reset.
- `mem_addr`  in  32  — byte address from the core's memory stage.
- `mem_wdata`  in  32  — store data.
- `mem_write`  in  1  — store strobe. When low, the access is a load or idle.
- `mem_rdata`  out  32  — registered read data, valid the cycle after the address.
- `io_valid`  out  1  — write buffer head valid.
- `io_ready`  in  1  — MMIO slave accepts the head entry.
- `io_addr`  out  32  — head entry address.
- `io_wdata`  out  32  — head entry data.
- `wbuf_overflow`  out  1  — sticky: at least one MMIO store was dropped.

## Operation

**Address decode**
- `mem_addr[31]==0`: RAM region. Word index is `mem_addr[log2(RAM_WORDS)+1:2]`; upper bits are ignored, so accesses alias/wrap. `mem_addr[1:0]` is ignored.
- `mem_addr[31]==1`: MMIO region.
- `mem_addr==32'hFFFF_FFFC`: control address (see below).

**RAM**
- Store: the word is written at the posedge.
- Every cycle: `mem_rdata <= ram[idx]` for RAM-region addresses, regardless of `mem_write`.
- Same-cycle write and read of one index returns the old data (read-before-write).
- RAM contents are not reset.

**MMIO store**
- Pushes `{mem_addr, mem_wdata}` into the FIFO if not full, or if a pop occurs in the same cycle.
- Otherwise the store is dropped and `wbuf_overflow` is set.

**MMIO load**
- Any MMIO-region load registers the status word into `mem_rdata`:
  - [31] `wbuf_overflow`
  - [30] full
  - [29] empty
  - [23:8] drop count
  - [7:0] occupancy
  - all other bits 0

**Control address**
- A store to `32'hFFFF_FFFC` is never pushed.
- It clears `wbuf_overflow` and the drop count.
- If a drop occurs in the same cycle, the clear wins.

**FIFO**
- Circular buffer with read/write pointers and a count of width `log2(WBUF_DEPTH)+1`.
- Pointers wrap modulo `WBUF_DEPTH`.
- `io_valid = (count != 0)`.
- `io_addr`/`io_wdata` show the head entry and are held stable until `io_valid & io_ready`.
- Pop occurs on `io_valid & io_ready`.
- Empty with push: the entry appears at the head the next cycle; there is no same-cycle bypass.
- Full with simultaneous push and pop: both happen and count is unchanged.

## Timing

- **Reset values:** `mem_rdata=0`, `io_valid=0`, `io_addr=0`, `io_wdata=0`, `wbuf_overflow=0`, count=0, pointers=0, drop count=0.
- **Reset mid-operation:** buffered entries are discarded immediately and asynchronously.
- **Load latency:** exactly 1 cycle, address → `mem_rdata`, for both RAM and status reads.
- **Store latency:**
  - RAM write is visible to a load issued the next cycle.
  - MMIO entry reaches `io_valid` 1 cycle after the store.
- **Status snapshot:** the status word reflects state before the current cycle's push/pop.
- **Drain rate:** 1 entry per cycle maximum.
- **Store order:** MMIO stores are issued in program order.

## Configuration

- `DBUS_DROP_COUNT_EN` defined:
  - Adds a 16-bit counter that increments on every dropped MMIO store and saturates at 16'hFFFF.
  - The counter is cleared by reset and by a control-address store.
  - Its value appears in status bits [23:8].
- Not defined:
  - No counter is built.
  - Status bits [23:8] read 0.
  - `wbuf_overflow` behaviour is unchanged.

## Test plan

- **RAM write/read:** store `0xDEADBEEF` to `0x0000_0010`, then load `0x10` next cycle → `mem_rdata==0xDEADBEEF` one cycle after the load address.
- **RAM aliasing:** with `RAM_WORDS=1024`, store `0x1234` to `0x0000_1010`, then load `0x10` → `0x1234`.
- **MMIO ordering:** with `io_ready=0`, store A to `0x8000_0000` and B to `0x8000_0004` → `io_valid=1` and head=A. Status load returns occupancy 2, empty 0. Raise `io_ready` → A then B on consecutive cycles, then `io_valid=0`.
- **Overflow:** `WBUF_DEPTH=4`, `io_ready=0`, 6 MMIO stores → 4 buffered and `wbuf_overflow=1`. Status [30]=1. Status [23:8]=2 with `DBUS_DROP_COUNT_EN`, 0 without. A store to `0xFFFF_FFFC` then clears the flag and the count.
- **Full with push and pop:** buffer full, `io_ready=1`, MMIO store in the same cycle → no drop, occupancy stays 4, and the new entry is drained last.
- **Async reset:** assert `reset` mid-drain with 3 entries buffered → `io_valid`, `mem_rdata`, `wbuf_overflow` go to 0 immediately without a clock edge, and the status reads empty after release.
